// File: rtl/tdm_demux_1_4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1_4
//
// Receive-side 1:4 time-division demultiplexer. Locks to a start-of-frame
// marker, steers each valid slot into its channel and presents the four
// channels together as one registered frame with a one-cycle strobe.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   din          slot sample
//   din_valid    din carries a slot this cycle (a "beat")
//   sof          marks din as slot 0 (ignored when din_valid=0)
//   y0..y3       channels 0..3 of the last completed frame
//   frame_valid  one-cycle pulse: y0..y3 just updated
//   locked       high once a sof has been seen (RUN state)
//   slot         slot index expected on the next beat
//   sync_err     one-cycle pulse on a sof arriving at slot 1..3
//   frame_cnt    completed frames, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module tdm_demux_1_4 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_slot;
  logic [WIDTH-1:0] r_shadow0, r_shadow1, r_shadow2;
  logic [WIDTH-1:0] r_y0, r_y1, r_y2, r_y3;
  logic             r_frame_valid;
  logic             r_sync_err;
  logic             r_locked;
  logic [CNT_W-1:0] r_frame_cnt;

  // A sof on any slot other than 0 means the transmitter and we disagree
  // about frame alignment; the beat restarts the frame as its slot 0.
  logic w_resync;
  assign w_resync = sof && (r_slot != 2'd0);

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow registers are reset too, so a partial frame can
      // never leak stale data into y0..y2 after a reset.
      r_state       <= HUNT;
      r_slot        <= 2'd0;
      r_shadow0     <= '0;
      r_shadow1     <= '0;
      r_shadow2     <= '0;
      r_y0          <= '0;
      r_y1          <= '0;
      r_y2          <= '0;
      r_y3          <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      // Pulses default low; only a qualifying beat raises them again.
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;

      if (din_valid) begin
        unique case (r_state)
          HUNT: begin
            // Beats before the first sof carry no alignment and are dropped.
            if (sof) begin
              r_shadow0 <= din;
              r_slot    <= 2'd1;
              r_locked  <= 1'b1;
              r_state   <= RUN;
            end
          end

          RUN: begin
            if (w_resync) begin
              // Abandon the partial frame; y0..y3 keep the last good frame.
              r_sync_err <= 1'b1;
              r_shadow0  <= din;
              r_slot     <= 2'd1;
            end else begin
              unique case (r_slot)
                2'd0: r_shadow0 <= din;
                2'd1: r_shadow1 <= din;
                2'd2: r_shadow2 <= din;
                2'd3: begin
                  // Last slot: publish the whole frame on a single edge.
                  r_y0          <= r_shadow0;
                  r_y1          <= r_shadow1;
                  r_y2          <= r_shadow2;
                  r_y3          <= din;
                  r_frame_valid <= 1'b1;
                  r_frame_cnt   <= r_frame_cnt + 1'b1;
                end
                default: ;
              endcase
              // Slot 3 wraps naturally to 0 in the 2-bit counter.
              r_slot <= r_slot + 2'd1;
            end
          end

          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign y0          = r_y0;
  assign y1          = r_y1;
  assign y2          = r_y2;
  assign y3          = r_y3;
  assign frame_valid = r_frame_valid;
  assign locked      = r_locked;
  assign slot        = r_slot;
  assign sync_err    = r_sync_err;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1_4
//
// Self-checking bench for tdm_demux_1_4. The stimulus process feeds beats to
// the DUT and to a queue-based frame-assembly model; the model pushes the
// expected frames and sync errors (with the edge they must appear on) into
// scoreboard queues, and an independent monitor pops and compares them
// whenever the DUT raises frame_valid or sync_err.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1_4;

  localparam int WIDTH = 1;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             sof = 1'b0;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic             frame_valid;
  logic             locked;
  logic [1:0]       slot;
  logic             sync_err;
  logic [CNT_W-1:0] frame_cnt;

  tdm_demux_1_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
    .sync_err    (sync_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;   // number of rising edges so far

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a frame is simply the list of samples collected since
  // the last alignment point; four samples make a frame.
  // ---------------------------------------------------------------------------
  typedef struct {
    int                 edge_no;
    logic [4*WIDTH-1:0] ys;       // {ch3, ch2, ch1, ch0}
    int                 cnt;
  } frame_exp_t;

  frame_exp_t       frame_q[$];
  int               sync_q[$];
  logic [WIDTH-1:0] m_part[$];
  bit               m_locked = 1'b0;
  int               m_cnt    = 0;

  function automatic void model_reset();
    m_part.delete();
    m_locked = 1'b0;
    m_cnt    = 0;
  endfunction

  // Called when a beat is driven; it will be sampled at edge cyc+1.
  function automatic void model_beat(input logic [WIDTH-1:0] d, input bit s);
    frame_exp_t f;
    if (!m_locked) begin
      if (s) begin
        m_locked = 1'b1;
        m_part.delete();
        m_part.push_back(d);
      end
    end else if (s && m_part.size() != 0) begin
      sync_q.push_back(cyc + 1);
      m_part.delete();
      m_part.push_back(d);
    end else begin
      m_part.push_back(d);
      if (m_part.size() == 4) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        f.edge_no = cyc + 1;
        f.ys      = {m_part[3], m_part[2], m_part[1], m_part[0]};
        f.cnt     = m_cnt;
        frame_q.push_back(f);
        m_part.delete();
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops expectations whenever the DUT presents a strobe.
  // ---------------------------------------------------------------------------
  logic               rst_q = 1'b1;
  logic [4*WIDTH-1:0] prev_y = '0;

  always @(posedge clk) rst_q = rst;

  always @(negedge clk) begin
    frame_exp_t f;
    int         e;
    if (frame_valid) begin
      if (frame_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL frame_valid_unexpected: got 1 expected 0 at edge %0d", cyc);
      end else begin
        f = frame_q.pop_front();
        check("frame_edge", cyc, f.edge_no);
        check("frame_y", {y3, y2, y1, y0}, f.ys);
        check("frame_cnt", frame_cnt, f.cnt);
      end
    end
    if (sync_err) begin
      if (sync_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sync_err_unexpected: got 1 expected 0 at edge %0d", cyc);
      end else begin
        e = sync_q.pop_front();
        check("sync_err_edge", cyc, e);
      end
    end
    // y may only move on a frame strobe or a reset edge.
    if (!rst_q && !frame_valid)
      check("y_stable", {y3, y2, y1, y0}, prev_y);
    prev_y = {y3, y2, y1, y0};
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change #1 after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic check_state();
    check("locked", locked, m_locked);
    check("slot", slot, m_part.size() % 4);
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input bit s);
    din       = d;
    sof       = s;
    din_valid = 1'b1;
    model_beat(d, s);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
    check_state();
  endtask

  // Idle cycles carry random din/sof garbage that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din       = WIDTH'($urandom);
      sof       = 1'($urandom);
      din_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    sof = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_y"}, {y3, y2, y1, y0}, 0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_slot"}, slot, 0);
    check({tag, "_sync_err"}, sync_err, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle.
    do_reset(2);
    idle(10);
    check_reset_outputs("reset_idle");

    // Garbage before sof, then frame 1,0,1,0.
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    check("hunt_locked", locked, 0);
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    check("decode_fv", frame_valid, 1);
    check("decode_y", {y3, y2, y1, y0}, 4'b0101);
    check("decode_cnt", frame_cnt, 1);
    idle(1);
    check("decode_fv_clear", frame_valid, 0);

    // Same frame with 3 idle cycles between beats.
    beat(1'b1, 1'b1);
    idle(3);
    beat(1'b0, 1'b0);
    idle(3);
    beat(1'b1, 1'b0);
    idle(3);
    beat(1'b0, 1'b0);
    check("gapped_y", {y3, y2, y1, y0}, 4'b0101);
    check("gapped_cnt", frame_cnt, 2);
    idle(2);

    // Resync: 1,1 then sof with 0, then 1,1,0.
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    check("resync_err", sync_err, 1);
    check("resync_slot", slot, 1);
    beat(1'b1, 1'b0);
    check("resync_err_clear", sync_err, 0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    check("resync_y", {y3, y2, y1, y0}, 4'b0110);
    check("resync_cnt", frame_cnt, 3);
    idle(2);

    // 300 back-to-back frames from reset, sof only on the first beat.
    do_reset(1);
    for (int j = 0; j < 1200; j++) begin
      beat(WIDTH'($urandom), j == 0);
      check("cont_fv_cadence", frame_valid, (j % 4) == 3);
    end
    check("cont_cnt", frame_cnt, 44);
    idle(2);

    // Reset after two beats of a frame.
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    do_reset(1);
    check_reset_outputs("mid_reset");
    for (int j = 0; j < 6; j++) beat(WIDTH'($urandom), 1'b0);
    check("post_reset_locked", locked, 0);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    check("post_reset_y", {y3, y2, y1, y0}, 4'b1110);
    idle(2);

    // Random traffic: gaps, occasional sof, rare resets.
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else if ($urandom_range(0, 9) < 7) begin
        beat(WIDTH'($urandom), $urandom_range(0, 99) < 8);
      end else begin
        idle(1);
      end
    end
    idle(4);

    check("frames_pending", frame_q.size(), 0);
    check("sync_pending", sync_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
